// File: rtl/mem_pkg.sv
// ============================================================================
// Module   : mem_pkg
// Purpose  : Shared defaults, access FSM state encoding and lock entry type.
// Revision : 1.0
// ============================================================================
`default_nettype none

package mem_pkg;

    localparam int c_ncore_def = 2;
    localparam int c_nlock_def = 16;
    localparam int c_owner_w   = 4;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WRITE     = 2'd1,
        ST_READ_WAIT = 2'd2,
        ST_ACK       = 2'd3
    } acc_state_t;

    typedef logic [c_owner_w-1:0] owner_t;

    typedef struct packed {
        logic   held;
        owner_t owner;
    } lock_entry_t;

endpackage

`default_nettype wire

// File: rtl/lock_table.sv
// ============================================================================
// Module   : lock_table
// Purpose  : Per-entry held/owner table serving lock and unlock requests.
// Revision : 1.0
// ============================================================================
`default_nettype none

module lock_table
    import mem_pkg::*;
#(
    parameter int NCORE = c_ncore_def,
    parameter int NLOCK = c_nlock_def
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NCORE-1:0]      lock_en,
    input  logic [NCORE-1:0]      unlock_en,
    input  logic [NCORE-1:0][3:0] lock_adr,
    output logic [NCORE-1:0]      lock_ac
);

    lock_entry_t      r_tab   [NLOCK];
    lock_entry_t      w_tab_n [NLOCK];
    logic [NCORE-1:0] r_ack;
    logic [NCORE-1:0] w_ack_n;

    // Cores are visited in index order against the partially updated table,
    // so the lower index wins a contended free entry.
    always_comb begin
        w_tab_n = r_tab;
        w_ack_n = '0;
        for (int i = 0; i < NCORE; i++) begin
            if (!r_ack[i] && (lock_en[i] || unlock_en[i])) begin
                if (int'(lock_adr[i]) >= NLOCK) begin
                    w_ack_n[i] = 1'b1;
                end else if (unlock_en[i]) begin
                    w_ack_n[i] = 1'b1;
                    if (w_tab_n[lock_adr[i]].held &&
                        w_tab_n[lock_adr[i]].owner == owner_t'(i)) begin
                        w_tab_n[lock_adr[i]].held = 1'b0;
                    end
                end else if (!w_tab_n[lock_adr[i]].held ||
                             w_tab_n[lock_adr[i]].owner == owner_t'(i)) begin
                    w_tab_n[lock_adr[i]].held  = 1'b1;
                    w_tab_n[lock_adr[i]].owner = owner_t'(i);
                    w_ack_n[i]                 = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < NLOCK; k++) begin
                r_tab[k] <= '0;
            end
            r_ack <= '0;
        end else begin
            r_tab <= w_tab_n;
            r_ack <= w_ack_n;
        end
    end

    assign lock_ac = r_ack;

endmodule

`default_nettype wire

// File: rtl/mem_responder.sv
// ============================================================================
// Module   : mem_responder
// Purpose  : Round-robin shared SRAM access responder plus lock table.
// Revision : 1.0
// ============================================================================
`default_nettype none

module mem_responder
    import mem_pkg::*;
#(
    parameter int NCORE = c_ncore_def,
    parameter int NLOCK = c_nlock_def
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NCORE-1:0]       main_mem_read_request,
    input  logic [NCORE-1:0]       main_mem_write_request,
    input  logic [NCORE-1:0][15:0] main_mem_read_adr,
    input  logic [NCORE-1:0][15:0] main_mem_write_adr,
    input  logic [NCORE-1:0][15:0] main_mem_write_dat,
    output logic [NCORE-1:0][15:0] main_mem_dat,
    output logic [NCORE-1:0]       main_mem_ac,
    input  logic [NCORE-1:0][3:0]  lock_adr,
    input  logic [NCORE-1:0]       lock_en,
    input  logic [NCORE-1:0]       unlock_en,
    output logic [NCORE-1:0]       lock_ac,
    output logic [15:0]            ram_adr,
    output logic [15:0]            ram_wdat,
    output logic                   ram_we,
    input  logic [15:0]            ram_rdat
);

    localparam int c_gw = (NCORE > 1) ? $clog2(NCORE) : 1;

    acc_state_t             r_state;
    acc_state_t             w_state_n;
    logic [c_gw-1:0]        r_grant;
    logic [c_gw-1:0]        w_grant_n;
    logic [c_gw-1:0]        r_last;
    logic [c_gw-1:0]        w_cand;
    logic [c_gw-1:0]        w_rr_idx;
    logic                   w_any;
    logic [NCORE-1:0]       w_req;
    logic [NCORE-1:0]       r_ac_mask;
    logic [NCORE-1:0]       w_ac;
    logic [NCORE-1:0][15:0] r_dat;

    // A core just acknowledged is still holding its request for one cycle.
    assign w_req = (main_mem_read_request | main_mem_write_request) & ~r_ac_mask;

    // Scan downwards so the requester nearest after r_last is the final pick.
    always_comb begin
        w_any    = 1'b0;
        w_cand   = r_last;
        w_rr_idx = '0;
        for (int k = NCORE; k >= 1; k--) begin
            w_rr_idx = c_gw'((int'(r_last) + k) % NCORE);
            if (w_req[w_rr_idx]) begin
                w_any  = 1'b1;
                w_cand = w_rr_idx;
            end
        end
    end

    always_comb begin
        w_state_n = r_state;
        w_grant_n = r_grant;
        ram_adr   = main_mem_read_adr[w_cand];
        ram_wdat  = main_mem_write_dat[r_grant];
        ram_we    = 1'b0;
        w_ac      = '0;
        case (r_state)
            ST_IDLE: begin
                if (w_any) begin
                    w_grant_n = w_cand;
                    w_state_n = main_mem_write_request[w_cand] ? ST_WRITE : ST_READ_WAIT;
                end
            end
            ST_WRITE: begin
                ram_we    = 1'b1;
                ram_adr   = main_mem_write_adr[r_grant];
                w_state_n = ST_ACK;
            end
            ST_READ_WAIT: begin
                ram_adr   = main_mem_read_adr[r_grant];
                w_state_n = ST_ACK;
            end
            ST_ACK: begin
                w_ac[r_grant] = 1'b1;
                w_state_n     = ST_IDLE;
            end
            default: w_state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_grant   <= '0;
            r_last    <= c_gw'(NCORE - 1);
            r_ac_mask <= '0;
            r_dat     <= '0;
        end else begin
            r_state   <= w_state_n;
            r_grant   <= w_grant_n;
            r_ac_mask <= w_ac;
            if (r_state == ST_READ_WAIT) begin
                r_dat[r_grant] <= ram_rdat;
            end
            if (r_state == ST_ACK) begin
                r_last <= r_grant;
            end
        end
    end

    assign main_mem_ac  = w_ac;
    assign main_mem_dat = r_dat;

    lock_table #(
        .NCORE (NCORE),
        .NLOCK (NLOCK)
    ) u_lock_table (
        .clk       (clk),
        .reset     (reset),
        .lock_en   (lock_en),
        .unlock_en (unlock_en),
        .lock_adr  (lock_adr),
        .lock_ac   (lock_ac)
    );

endmodule

`default_nettype wire

// File: tb/tb_mem_responder.sv
// ============================================================================
// Module   : tb_mem_responder
// Purpose  : Directed scoreboard bench for mem_responder with an SRAM model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_mem_responder;

    localparam int NC = 2;

    logic                clk = 1'b0;
    logic                reset = 1'b1;
    logic [NC-1:0]       main_mem_read_request  = '0;
    logic [NC-1:0]       main_mem_write_request = '0;
    logic [NC-1:0][15:0] main_mem_read_adr      = '0;
    logic [NC-1:0][15:0] main_mem_write_adr     = '0;
    logic [NC-1:0][15:0] main_mem_write_dat     = '0;
    logic [NC-1:0][15:0] main_mem_dat;
    logic [NC-1:0]       main_mem_ac;
    logic [NC-1:0][3:0]  lock_adr  = '0;
    logic [NC-1:0]       lock_en   = '0;
    logic [NC-1:0]       unlock_en = '0;
    logic [NC-1:0]       lock_ac;
    logic [15:0]         ram_adr;
    logic [15:0]         ram_wdat;
    logic                ram_we;
    logic [15:0]         ram_rdat = '0;

    mem_responder #(.NCORE(NC), .NLOCK(16)) dut (
        .clk                    (clk),
        .reset                  (reset),
        .main_mem_read_request  (main_mem_read_request),
        .main_mem_write_request (main_mem_write_request),
        .main_mem_read_adr      (main_mem_read_adr),
        .main_mem_write_adr     (main_mem_write_adr),
        .main_mem_write_dat     (main_mem_write_dat),
        .main_mem_dat           (main_mem_dat),
        .main_mem_ac            (main_mem_ac),
        .lock_adr               (lock_adr),
        .lock_en                (lock_en),
        .unlock_en              (unlock_en),
        .lock_ac                (lock_ac),
        .ram_adr                (ram_adr),
        .ram_wdat               (ram_wdat),
        .ram_we                 (ram_we),
        .ram_rdat               (ram_rdat)
    );

    always #5 clk = ~clk;

    // Unwritten words read back as address ^ 0xC3C3.
    logic [15:0] sram    [65536];
    bit          written [65536];
    always @(posedge clk) begin
        if (ram_we) begin
            sram[ram_adr]    <= ram_wdat;
            written[ram_adr] <= 1'b1;
        end
        ram_rdat <= written[ram_adr] ? sram[ram_adr] : (ram_adr ^ 16'hC3C3);
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        string       tag;
        bit          lk;
        int          core;
        int          kind;   // 0 read, 1 write, 2 lock, 3 unlock
        int          start;
        int          lat;
        bit          chk;
        logic [15:0] dat;
    } exp_t;

    exp_t q[$];
    int   total  = 0;
    int   passed = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) begin
            passed++;
        end else begin
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drop(input exp_t e);
        case (e.kind)
            0:       main_mem_read_request[e.core]  = 1'b0;
            1:       main_mem_write_request[e.core] = 1'b0;
            2:       lock_en[e.core]                = 1'b0;
            default: unlock_en[e.core]              = 1'b0;
        endcase
    endtask

    task automatic raise_acc(input int c, input int kind, input logic [15:0] adr, input logic [15:0] dat);
        if (kind == 1) begin
            main_mem_write_request[c] = 1'b1;
            main_mem_write_adr[c]     = adr;
            main_mem_write_dat[c]     = dat;
        end else begin
            main_mem_read_request[c] = 1'b1;
            main_mem_read_adr[c]     = adr;
        end
    endtask

    task automatic raise_lock(input int c, input bit unl, input logic [3:0] a);
        lock_adr[c] = a;
        if (unl) unlock_en[c] = 1'b1;
        else     lock_en[c]   = 1'b1;
    endtask

    task automatic expect_ack(input string tag, input bit lk, input int c, input int kind,
                              input int lat, input bit chk, input logic [15:0] dat);
        exp_t e;
        e.tag = tag; e.lk = lk; e.core = c; e.kind = kind;
        e.start = cyc; e.lat = lat; e.chk = chk; e.dat = dat;
        q.push_back(e);
    endtask

    task automatic handle(input bit lk, input int c);
        int idx = -1;
        for (int k = 0; k < q.size(); k++) begin
            if (idx < 0 && q[k].lk == lk && q[k].core == c) idx = k;
        end
        total++;
        assert (idx >= 0) begin
            passed++;
        end else begin
            $error("FAIL unexpected_ack: port %0d core %0d acked, expected no ack", lk, c);
        end
        if (idx >= 0) begin
            exp_t e;
            e = q[idx];
            q.delete(idx);
            check({e.tag, "_lat"}, cyc - e.start, e.lat);
            if (e.chk) check({e.tag, "_dat"}, main_mem_dat[c], e.dat);
            drop(e);
        end
    endtask

    task automatic run(input int budget);
        int n = 0;
        while (q.size() > 0 && n < budget) begin
            @(negedge clk);
            n++;
            for (int c = 0; c < NC; c++) begin
                if (main_mem_ac[c]) handle(1'b0, c);
                if (lock_ac[c])     handle(1'b1, c);
            end
        end
        while (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            check({e.tag, "_timeout"}, cyc - e.start, e.lat);
            drop(e);
        end
    endtask

    task automatic quiet(input int n);
        repeat (n) begin
            @(negedge clk);
            check("no_ack", {28'h0, main_mem_ac, lock_ac}, 32'h0);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        check("rst_mem_ac", {30'h0, main_mem_ac}, 32'h0);
        check("rst_lock_ac", {30'h0, lock_ac}, 32'h0);
        check("rst_mem_dat", main_mem_dat, 32'h0);
        check("rst_ram_we", {31'h0, ram_we}, 32'h0);
        reset = 1'b0;
        @(negedge clk);
        check("post_rst_acks", {28'h0, main_mem_ac, lock_ac}, 32'h0);

        // Simultaneous reads straight after reset: core0 first, core1 3 cycles later
        raise_acc(0, 0, 16'h0040, 16'h0);
        raise_acc(1, 0, 16'h0041, 16'h0);
        expect_ack("rd_both_c0", 1'b0, 0, 0, 2, 1'b1, 16'hC383);
        expect_ack("rd_both_c1", 1'b0, 1, 0, 5, 1'b1, 16'hC382);
        run(20);
        check("dat0_hold", main_mem_dat[0], 16'hC383);
        quiet(2);

        // Write then read back on core0
        raise_acc(0, 1, 16'h0010, 16'hBEEF);
        expect_ack("wr_c0", 1'b0, 0, 1, 2, 1'b0, 16'h0);
        run(10);
        quiet(2);
        raise_acc(0, 0, 16'h0010, 16'h0);
        expect_ack("rd_c0", 1'b0, 0, 0, 2, 1'b1, 16'hBEEF);
        run(10);
        quiet(2);

        // Write and read together: write first, read after the post-ack gap
        raise_acc(0, 1, 16'h0020, 16'h1234);
        raise_acc(0, 0, 16'h0020, 16'h0);
        expect_ack("wrrd_w", 1'b0, 0, 1, 2, 1'b0, 16'h0);
        expect_ack("wrrd_r", 1'b0, 0, 0, 6, 1'b1, 16'h1234);
        run(20);
        quiet(2);

        // Both write: core0 was last granted, so core1 goes first
        raise_acc(1, 1, 16'h0050, 16'h1111);
        raise_acc(0, 1, 16'h0051, 16'h2222);
        expect_ack("wr_rr_c1", 1'b0, 1, 1, 2, 1'b0, 16'h0);
        expect_ack("wr_rr_c0", 1'b0, 0, 1, 5, 1'b0, 16'h0);
        run(20);
        quiet(2);
        raise_acc(0, 0, 16'h0050, 16'h0);
        raise_acc(1, 0, 16'h0051, 16'h0);
        expect_ack("rd_rr_c1", 1'b0, 1, 0, 2, 1'b1, 16'h2222);
        expect_ack("rd_rr_c0", 1'b0, 0, 0, 5, 1'b1, 16'h1111);
        run(20);
        check("dat1_hold", main_mem_dat[1], 16'h2222);
        quiet(2);

        // Lock contention on entry 3, concurrent with an access
        raise_lock(0, 1'b0, 4'd3);
        raise_acc(1, 1, 16'h0060, 16'h7777);
        expect_ack("lk3_c0", 1'b1, 0, 2, 1, 1'b0, 16'h0);
        expect_ack("wr_conc_c1", 1'b0, 1, 1, 2, 1'b0, 16'h0);
        run(10);
        raise_lock(1, 1'b0, 4'd3);
        quiet(4);
        raise_lock(0, 1'b1, 4'd3);
        expect_ack("ulk3_c0", 1'b1, 0, 3, 1, 1'b0, 16'h0);
        expect_ack("lk3_c1", 1'b1, 1, 2, 1, 1'b0, 16'h0);
        run(10);
        quiet(1);
        raise_lock(1, 1'b1, 4'd3);
        expect_ack("ulk3_c1", 1'b1, 1, 3, 1, 1'b0, 16'h0);
        run(10);
        quiet(1);

        // Same-cycle lock on entry 5: core0 wins, core1 stalls
        raise_lock(0, 1'b0, 4'd5);
        raise_lock(1, 1'b0, 4'd5);
        expect_ack("lk5_c0", 1'b1, 0, 2, 1, 1'b0, 16'h0);
        run(10);
        quiet(3);
        // Non-owner unlock with lock also high: unlock wins, acked, no state change
        raise_lock(1, 1'b1, 4'd5);
        expect_ack("ulk5_c1", 1'b1, 1, 3, 1, 1'b0, 16'h0);
        run(10);
        quiet(3);
        lock_en[1] = 1'b0;
        quiet(1);
        raise_lock(0, 1'b0, 4'd5);
        expect_ack("relk5_c0", 1'b1, 0, 2, 1, 1'b0, 16'h0);
        run(10);
        quiet(2);

        // Reset during READ_WAIT aborts the read and frees all locks
        raise_acc(0, 0, 16'h0010, 16'h0);
        @(negedge clk);
        check("rw_no_ack", {30'h0, main_mem_ac}, 32'h0);
        main_mem_read_request[0] = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("rst2_mem_ac", {30'h0, main_mem_ac}, 32'h0);
        check("rst2_mem_dat", main_mem_dat, 32'h0);
        quiet(3);
        raise_lock(1, 1'b0, 4'd5);
        expect_ack("lk5_after_rst", 1'b1, 1, 2, 1, 1'b0, 16'h0);
        run(10);
        quiet(2);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

`default_nettype wire
